// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state encoding for the FFT stage sequencer
package fft_pkg;
    localparam int LOG2N   = 8;
    localparam int N       = 1 << LOG2N;
    localparam int BF_LAT  = 3;
    localparam int STAGE_W = 4;
    localparam int CNT_W   = $clog2(BF_LAT + 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    typedef logic [STAGE_W-1:0] stage_t;
endpackage

// File: rtl/fft_stage_ctrl_if.sv
// rtl/fft_stage_ctrl_if.sv - control/generator signal bundle of the FFT stage sequencer
interface fft_stage_ctrl_if;
    import fft_pkg::*;

    logic   start;
    logic   abort;
    logic   agen_done;
    logic   agen_en;
    stage_t stage;
    logic   rd_valid;
    logic   bf_we;
    logic   bank_sel;
    logic   busy;
    logic   done;

    modport master (
        input  start, abort, agen_done,
        output agen_en, stage, rd_valid, bf_we, bank_sel, busy, done
    );

    modport slave (
        output start, abort, agen_done,
        input  agen_en, stage, rd_valid, bf_we, bank_sel, busy, done
    );
endinterface

// File: rtl/fft_valid_delay.sv
// rtl/fft_valid_delay.sv - DEPTH-cycle valid shift register with synchronous clear
module fft_valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = (sr_q << 1) | DEPTH'(din);
        if (clr) begin
            sr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - steps the butterfly address generator through all FFT stages
module fft_stage_ctrl
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fft_stage_ctrl_if.master bus
);
    state_t           state_q, state_d;
    stage_t           stage_q, stage_d;
    logic             bank_q, bank_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_valid_q, rd_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stage_q    <= STAGE_W'(1);
            bank_q     <= 1'b0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            bank_q     <= bank_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        bank_d     = bank_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_GAP;
                    stage_d = STAGE_W'(1);
                    bank_d  = 1'b0;
                end
            end
            ST_GAP: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_valid_d = ~bus.agen_done;
                if (bus.agen_done) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(BF_LAT + 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    if (stage_q == STAGE_W'(LOG2N)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_GAP;
                        stage_d = stage_q + STAGE_W'(1);
                        bank_d  = ~bank_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                bank_d  = ~bank_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort wins over every transition; the bank in use is kept for inspection.
        if (bus.abort) begin
            state_d    = ST_IDLE;
            stage_d    = stage_q;
            bank_d     = bank_q;
            cnt_d      = '0;
            rd_valid_d = 1'b0;
        end
    end

    fft_valid_delay #(
        .DEPTH (BF_LAT)
    ) u_we_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.abort),
        .din  (rd_valid_q),
        .dout (bus.bf_we)
    );

    assign bus.agen_en  = (state_q == ST_RUN);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_FIN);
    assign bus.stage    = stage_q;
    assign bus.bank_sel = bank_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - randomized self-checking bench for fft_stage_ctrl
module tb_fft_stage_ctrl;
    import fft_pkg::*;

    localparam int HALF  = N / 2;
    localparam int SC    = 1 + (HALF + 1) + (BF_LAT + 2);
    localparam int FIN_K = LOG2N * SC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_stage_ctrl_if bus();

    fft_stage_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    int   gen_cnt = 0;
    logic noise   = 1'b0;
    assign bus.agen_done = (bus.agen_en && gen_cnt == HALF) || (noise && !bus.agen_en);

    always @(posedge clk) begin
        if (rst || !bus.agen_en) gen_cnt <= 0;
        else if (gen_cnt < HALF) gen_cnt <= gen_cnt + 1;
    end

    bit armed     = 1'b0;
    bit active    = 1'b0;
    int k         = 0;
    bit hold_bank = 1'b0;

    function automatic bit f_bank(input int kk);
        if (kk >= FIN_K) return bit'((LOG2N - 1) % 2);
        return bit'((kk / SC) % 2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            armed     <= 1'b1;
            active    <= 1'b0;
            k         <= 0;
            hold_bank <= 1'b0;
        end else if (active) begin
            if (bus.abort) begin
                active    <= 1'b0;
                hold_bank <= f_bank(k);
            end else if (k == FIN_K) begin
                active    <= 1'b0;
                hold_bank <= bit'(LOG2N % 2);
            end else begin
                k <= k + 1;
            end
        end else if (bus.start && !bus.abort) begin
            active <= 1'b1;
            k      <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int  rd_cnt [16];
    int  bf_cnt [16];
    int  en_cnt [16];
    int  done_cnt = 0;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        int  s, w, e_stage;
        bit  e_busy, e_en, e_rd, e_bf, e_done, e_bank;
        if (armed) begin
            e_stage = 1;
            if (!active) begin
                e_busy = 0; e_en = 0; e_rd = 0; e_bf = 0; e_done = 0; e_bank = hold_bank;
            end else if (k == FIN_K) begin
                e_busy = 1; e_en = 0; e_rd = 0; e_bf = 0; e_done = 1; e_bank = f_bank(k);
                e_stage = LOG2N;
            end else begin
                s = k / SC;
                w = k % SC;
                e_busy  = 1;
                e_done  = 0;
                e_en    = (w >= 1 && w <= HALF + 1);
                e_rd    = (w >= 2 && w <= HALF + 1);
                e_bf    = (w >= 2 + BF_LAT && w <= HALF + 1 + BF_LAT);
                e_bank  = f_bank(k);
                e_stage = s + 1;
            end
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("agen_en", 32'(bus.agen_en), 32'(e_en));
            chk("rd_valid", 32'(bus.rd_valid), 32'(e_rd));
            chk("bf_we", 32'(bus.bf_we), 32'(e_bf));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("bank_sel", 32'(bus.bank_sel), 32'(e_bank));
            if (active) chk("stage", 32'(bus.stage), 32'(e_stage));
            if (bus.rd_valid === 1'b1) rd_cnt[bus.stage] = rd_cnt[bus.stage] + 1;
            if (bus.bf_we === 1'b1) bf_cnt[bus.stage] = bf_cnt[bus.stage] + 1;
            if (bus.agen_en === 1'b1 && !prev_en) en_cnt[bus.stage] = en_cnt[bus.stage] + 1;
            if (bus.done === 1'b1) done_cnt = done_cnt + 1;
            prev_en = bus.agen_en;
        end
    end

    task automatic tick();
        @(negedge clk);
        noise = 1'($urandom % 2);
    endtask

    task automatic run_full(input int poke_k);
        int b_rd [16];
        int b_bf [16];
        int b_en [16];
        int b_done;
        int cyc;
        for (int s = 0; s < 16; s++) begin
            b_rd[s] = rd_cnt[s]; b_bf[s] = bf_cnt[s]; b_en[s] = en_cnt[s];
        end
        b_done = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("first_gap_stage", 32'(bus.stage), 32'd1);
        chk("first_gap_bank", 32'(bus.bank_sel), 32'd0);
        chk("first_gap_en", 32'(bus.agen_en), 32'd0);
        cyc = 0;
        while (active && cyc < FIN_K + 50) begin
            bus.start = (k == poke_k) || ($urandom % 32 == 0);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        chk("run_timeout", 32'(active), 32'd0);
        for (int s = 1; s <= LOG2N; s++) begin
            chk($sformatf("rd_pulses_s%0d", s), 32'(rd_cnt[s] - b_rd[s]), 32'd128);
            chk($sformatf("bf_pulses_s%0d", s), 32'(bf_cnt[s] - b_bf[s]), 32'd128);
            chk($sformatf("gap_run_s%0d", s), 32'(en_cnt[s] - b_en[s]), 32'd1);
        end
        chk("done_once", 32'(done_cnt - b_done), 32'd1);
        chk("final_bank", 32'(bus.bank_sel), 32'd0);
        chk("final_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int b_done;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int s = 0; s < 16; s++) begin
            rd_cnt[s] = 0; bf_cnt[s] = 0; en_cnt[s] = 0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_agen_en", 32'(bus.agen_en), 32'd0);
        chk("rst_stage", 32'(bus.stage), 32'd1);
        chk("rst_bank", 32'(bus.bank_sel), 32'd0);
        chk("rst_bf_we", 32'(bus.bf_we), 32'd0);
        repeat (20) tick();
        chk("idle_no_done", 32'(done_cnt), 32'd0);
        chk("idle_stage", 32'(bus.stage), 32'd1);

        run_full(-1);
        repeat (3) tick();
        run_full(3 * SC + 60);
        repeat (3) tick();

        b_done = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!(active && k == 4 * SC + 131) && cyc < FIN_K) begin
            tick();
            cyc++;
        end
        chk("abort_reach", 32'(k), 32'(4 * SC + 131));
        chk("abort_pre_bf", 32'(bus.bf_we), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_bf_we", 32'(bus.bf_we), 32'd0);
        chk("abort_stage_held", 32'(bus.stage), 32'd5);
        repeat (5) tick();
        chk("abort_no_done", 32'(done_cnt - b_done), 32'd0);
        run_full(-1);
        repeat (3) tick();

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!(active && k == SC + 50) && cyc < FIN_K) begin
            tick();
            cyc++;
        end
        chk("rst_mid_stage2", 32'(bus.stage), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_en", 32'(bus.agen_en), 32'd0);
        chk("rst_mid_stage", 32'(bus.stage), 32'd1);
        chk("rst_mid_bank", 32'(bus.bank_sel), 32'd0);
        chk("rst_mid_rd", 32'(bus.rd_valid), 32'd0);
        repeat (4) tick();
        chk("rst_mid_bf", 32'(bus.bf_we), 32'd0);
        run_full(-1);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
